instruction_fetch: RTL
======================

// Module: instruction_fetch
// PURPOSE
//  Requester side of the instruction-ROM interface. Holds the PC, drives address/chip_select/output_enable
//  toward the ROM, samples the 64-bit ROM data bus after a fixed wait, and presents the low 32 bits plus
//  their PC to decode over a valid/ready handshake. Redirects (branches) from the datapath reload the PC
//  and flush any fetched-but-unconsumed instruction. Sits between the ROM and the decode stage.
// PARAMETERS
//  RESET_PC  32'h00000000  PC loaded on reset.
//  ROM_WAIT  1             Cycles CS/OE are held before rom_data is sampled (legal range 1..15).
// PORTS
//  clock              in   1   single clock, all state updates on rising edge
//  reset              in   1   asynchronous, active-high; clears all state immediately
//  enable             in   1   1 = fetching permitted; sampled only in IDLE and at handoff
//  redirect           in   1   1 = load redirect_pc, discard in-flight/held instruction
//  redirect_pc        in   32  new PC; bits [1:0] forced to 0
//  rom_address        out  32  byte address to ROM (= PC)
//  rom_chip_select    out  1   1 only while in FETCH
//  rom_output_enable  out  1   1 only while in FETCH
//  rom_data           in   64  ROM read data; only [31:0] used, [63:32] ignored
//  instr              out  32  fetched instruction
//  instr_pc           out  32  PC of instr
//  instr_valid        out  1   instr/instr_pc valid
//  instr_ready        in   1   decode accepts when instr_valid & instr_ready
// BEHAVIOUR
//  Reset values: pc=RESET_PC, state=IDLE, wait_cnt=0, instr=0, instr_pc=0, instr_valid=0,
//   rom_chip_select=0, rom_output_enable=0; rom_address=pc at all times (so RESET_PC out of reset).
//  States: IDLE, FETCH, HOLD.
//   IDLE:  enable=1 -> FETCH, wait_cnt<=ROM_WAIT. Else stay.
//   FETCH: CS=OE=1. wait_cnt decrements each cycle; on the edge where wait_cnt==1: instr<=rom_data[31:0],
//          instr_pc<=pc, pc<=pc+4, instr_valid<=1 -> HOLD. enable is ignored in FETCH (fetch completes).
//   HOLD:  CS=OE=0; instr/instr_pc stable while instr_valid & ~instr_ready.
//          On instr_ready: instr_valid<=0; enable=1 -> FETCH (wait_cnt<=ROM_WAIT), else -> IDLE.
//  Latency: ROM_WAIT cycles from FETCH entry to instr_valid=1; throughput one instr per ROM_WAIT+1 cycles
//   with decode always ready.
//  Redirect (highest priority, any state): pc<={redirect_pc[31:2],2'b00}, instr_valid<=0, wait_cnt<=0,
//   state<=IDLE if enable=0 else FETCH with wait_cnt<=ROM_WAIT. A held instr is discarded even if
//   instr_ready=1 in the same cycle (handoff does not occur). An in-flight FETCH sample is dropped.
//  PC arithmetic: 32-bit unsigned, pc+4 wraps 32'hFFFFFFFC -> 32'h00000000 with no flag.
//  Unmapped ROM addresses return 0; 32'h00000000 is passed to decode as an ordinary instruction.
//  Reset asserted mid-FETCH or HOLD: all outputs to reset values asynchronously; held instr is lost.
//  rom_data is not sampled outside the wait_cnt==1 edge of FETCH (bus may be high-Z otherwise).
// STRUCTURE
//  fetch_pkg: state enum {IDLE,FETCH,HOLD}; INSTR_W=32, ROM_DATA_W=64, ADDR_W=32, PC_STEP=4.
//  One sub-module: fetch_wait_counter (4-bit load/decrement, done=cnt==1). PC, FSM and output
//  registers stay in instruction_fetch.
// TESTING
//  1 Reset, enable=1, ready=1, ROM_WAIT=1, ROM[0]=0x9101EFE0 -> CS/OE high 1 cycle at addr 0; then
//    instr=0x9101EFE0, instr_pc=0, valid=1; next fetch at addr 4.
//  2 ready=0 for 5 cycles while valid -> instr/instr_pc stable, CS=OE=0, rom_address=4; ready=1 -> fetch 4.
//  3 ROM_WAIT=3 -> CS/OE high exactly 3 cycles; changing rom_data on cycles 1-2 not captured, cycle-3 value is.
//  4 redirect=1, redirect_pc=0x0000001E while HOLD & ready=1 -> no handoff, valid=0, next address 0x1C.
//  5 Reset asserted mid-FETCH -> CS/OE/valid drop same cycle, rom_address=RESET_PC; redirect_pc=0xFFFFFFFC
//    -> fetch at 0xFFFFFFFC then 0x00000000 (wrap).
//  6 enable=0 while FETCH -> fetch completes; after handoff state IDLE, CS=0, PC held until enable=1.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and widths for the instruction fetch block.
//   state_t    : fetch FSM states (IDLE, FETCH, HOLD)
//   INSTR_W    : instruction width handed to decode
//   ROM_DATA_W : ROM data bus width (only the low INSTR_W bits are used)
//   ADDR_W     : byte address / PC width
//   PC_STEP    : PC increment per fetched instruction
//   WAIT_W     : width of the ROM wait counter
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned ROM_DATA_W = 64;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WAIT_W     = 4;
  localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: bundles the fetch unit's control inputs, the instruction-ROM bus
// and the decode valid/ready handshake.
//   master : the fetch unit (drives ROM address/strobes and instr outputs)
//   slave  : the environment (datapath control, ROM and decode)
interface fetch_if;
  import fetch_pkg::*;

  logic                  enable;
  logic                  redirect;
  logic [ADDR_W-1:0]     redirect_pc;
  logic [ADDR_W-1:0]     rom_address;
  logic                  rom_chip_select;
  logic                  rom_output_enable;
  logic [ROM_DATA_W-1:0] rom_data;
  logic [INSTR_W-1:0]    instr;
  logic [ADDR_W-1:0]     instr_pc;
  logic                  instr_valid;
  logic                  instr_ready;

  modport master (
    input  enable, redirect, redirect_pc, rom_data, instr_ready,
    output rom_address, rom_chip_select, rom_output_enable,
           instr, instr_pc, instr_valid
  );

  modport slave (
    output enable, redirect, redirect_pc, rom_data, instr_ready,
    input  rom_address, rom_chip_select, rom_output_enable,
           instr, instr_pc, instr_valid
  );

endinterface

// File: rtl/fetch_wait_counter.sv
// fetch_wait_counter: ROM access wait counter.
//   clock, reset : clock and asynchronous active-high reset
//   load         : load load_val (takes priority over dec)
//   load_val     : value to load
//   dec          : decrement by one, saturating at zero
//   done         : counter is at 1, i.e. this edge is the sampling edge
module fetch_wait_counter
  import fetch_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_val,
  input  logic              dec,
  output logic              done
);

  logic [WAIT_W-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign done = (cnt == WAIT_W'(1));

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: requester side of the instruction ROM.
// Holds the PC, strobes the ROM for ROM_WAIT cycles, captures the low word of
// rom_data and offers it to decode with its PC over valid/ready. A redirect
// reloads the PC and discards any in-flight or held instruction.
//   clock, reset : clock and asynchronous active-high reset
//   bus          : fetch_if.master (enable/redirect control, ROM bus, decode handshake)
//   RESET_PC     : PC after reset
//   ROM_WAIT     : cycles the ROM strobes are held before sampling (1..15)
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned       ROM_WAIT = 1
) (
  input  logic     clock,
  input  logic     reset,
  fetch_if.master  bus
);

  localparam logic [WAIT_W-1:0] WAIT_LD = WAIT_W'(ROM_WAIT);

  state_t             state, state_n;
  logic [ADDR_W-1:0]  pc;
  logic [INSTR_W-1:0] instr_q;
  logic [ADDR_W-1:0]  instr_pc_q;
  logic               valid_q;

  logic               cnt_load, cnt_dec, cnt_done;
  logic [WAIT_W-1:0]  cnt_val;
  logic               capture, handoff;

  // Upper half of the ROM word is not part of the instruction.
  logic unused_rom_hi;
  assign unused_rom_hi = ^bus.rom_data[ROM_DATA_W-1:INSTR_W];

  fetch_wait_counter u_wait (
    .clock    (clock),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .done     (cnt_done)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Redirect overrides everything: no capture and no handoff on that edge.
  always_comb begin
    state_n  = state;
    cnt_load = 1'b0;
    cnt_val  = WAIT_LD;
    cnt_dec  = 1'b0;
    capture  = 1'b0;
    handoff  = 1'b0;
    if (bus.redirect) begin
      cnt_load = 1'b1;
      if (bus.enable) begin
        state_n = FETCH;
      end else begin
        state_n = IDLE;
        cnt_val = '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.enable) begin
            state_n  = FETCH;
            cnt_load = 1'b1;
          end
        end
        FETCH: begin
          cnt_dec = 1'b1;
          if (cnt_done) begin
            capture = 1'b1;
            state_n = HOLD;
          end
        end
        HOLD: begin
          if (bus.instr_ready) begin
            handoff = 1'b1;
            if (bus.enable) begin
              state_n  = FETCH;
              cnt_load = 1'b1;
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
    end else if (bus.redirect) begin
      pc      <= {bus.redirect_pc[ADDR_W-1:2], 2'b00};
      valid_q <= 1'b0;
    end else if (capture) begin
      instr_q    <= bus.rom_data[INSTR_W-1:0];
      instr_pc_q <= pc;
      pc         <= pc + PC_STEP;   // wraps silently at the top of the space
      valid_q    <= 1'b1;
    end else if (handoff) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.rom_address       = pc;
  assign bus.rom_chip_select   = (state == FETCH);
  assign bus.rom_output_enable = (state == FETCH);
  assign bus.instr             = instr_q;
  assign bus.instr_pc          = instr_pc_q;
  assign bus.instr_valid       = valid_q;

endmodule
